// File: rtl/i2c_slave_regs.sv
// Oversampled I2C slave giving a bus master byte access to a 2^ADDR_W register space.
// Writes leave as one-cycle strobes; reads are fetched from fabric through RD_ADDR/RD_DATA.
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h72,
   parameter int         ADDR_W     = 4,
   parameter int         FILT       = 3
) (
   input  logic              CLCK,
   input  logic              RST,
   input  logic              SCL,
   inout  wire               SDA,
   input  logic [7:0]        RD_DATA,
   output logic [ADDR_W-1:0] RD_ADDR,
   output logic              WR_STB,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [7:0]        WR_DATA,
   output logic              BUSY
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
   } state_t;

   localparam logic [2:0]        FILT_LAST = 3'(FILT - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0] line_raw;
   logic [1:0] line_filt;
   logic [1:0] line_prev_reg;

   assign line_raw = {SDA, SCL};

   // Bit 0 is SCL, bit 1 is SDA; both reset to the idle-high bus level.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_line
         logic [1:0] sync_reg;
         logic [2:0] cnt_reg;
         logic       filt_reg;

         always_ff @(posedge CLCK) begin
            if (RST) begin
               sync_reg <= 2'b11;
               cnt_reg  <= '0;
               filt_reg <= 1'b1;
            end else begin
               sync_reg <= {sync_reg[0], line_raw[gi]};
               if (sync_reg[1] == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == FILT_LAST) begin
                  cnt_reg  <= '0;
                  filt_reg <= sync_reg[1];
               end else begin
                  cnt_reg <= cnt_reg + 3'd1;
               end
            end
         end

         assign line_filt[gi] = filt_reg;
      end
   endgenerate

   always_ff @(posedge CLCK) begin
      if (RST) line_prev_reg <= 2'b11;
      else     line_prev_reg <= line_filt;
   end

   logic scl_f, sda_f, scl_prev, sda_prev;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_f     = line_filt[0];
   assign sda_f     = line_filt[1];
   assign scl_prev  = line_prev_reg[0];
   assign sda_prev  = line_prev_reg[1];
   assign scl_rise  = scl_f & ~scl_prev;
   assign scl_fall  = ~scl_f & scl_prev;
   assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
   assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

   state_t            state_reg, state_next;
   logic [3:0]        bit_cnt_reg, bit_cnt_next;
   logic [7:0]        shift_reg, shift_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic              rw_reg, rw_next;
   logic              busy_reg, busy_next;
   logic              sda_oe_reg, sda_oe_next;
   logic              wr_stb_reg, wr_stb_next;
   logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
   logic [7:0]        wr_data_reg, wr_data_next;
   logic              load_rd;

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      ptr_next     = ptr_reg;
      rw_next      = rw_reg;
      busy_next    = busy_reg;
      sda_oe_next  = sda_oe_reg;
      wr_stb_next  = 1'b0;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;
      load_rd      = 1'b0;

      if (stop_det) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         sda_oe_next  = 1'b0;
         busy_next    = 1'b0;
      end else if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = '0;
         sda_oe_next  = 1'b0;
      end else begin
         case (state_reg)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shift_next   = {shift_reg[6:0], sda_f};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = '0;
                  sda_oe_next  = 1'b1;
                  case (state_reg)
                     ADDR: begin
                        if (shift_reg[7:1] == SLAVE_ADDR) begin
                           state_next = ADDR_ACK;
                           busy_next  = 1'b1;
                           rw_next    = shift_reg[0];
                        end else begin
                           state_next  = IGNORE;
                           sda_oe_next = 1'b0;
                           busy_next   = 1'b0;
                        end
                     end
                     PTR: begin
                        ptr_next   = shift_reg[ADDR_W-1:0];
                        state_next = PTR_ACK;
                     end
                     default: begin
                        wr_stb_next  = 1'b1;
                        wr_addr_next = ptr_reg;
                        wr_data_next = shift_reg;
                        ptr_next     = ptr_reg + PTR_ONE;
                        state_next   = WDATA_ACK;
                     end
                  endcase
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw_reg) begin
                     load_rd = 1'b1;
                  end else begin
                     state_next  = PTR;
                     sda_oe_next = 1'b0;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  state_next  = WDATA;
                  sda_oe_next = 1'b0;
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     state_next   = RACK;
                     bit_cnt_next = '0;
                     sda_oe_next  = 1'b0;
                  end else begin
                     shift_next  = {shift_reg[6:0], 1'b0};
                     sda_oe_next = ~shift_reg[6];
                  end
               end
            end
            RACK: begin
               // bit_cnt doubles as the "master acknowledged" flag here
               if (scl_rise) begin
                  if (sda_f) begin
                     state_next = IGNORE;
                     busy_next  = 1'b0;
                  end else begin
                     bit_cnt_next = 4'd1;
                  end
               end else if (scl_fall && bit_cnt_reg == 4'd1) begin
                  load_rd = 1'b1;
               end
            end
            default: ;
         endcase

         if (load_rd) begin
            state_next   = RDATA;
            bit_cnt_next = '0;
            shift_next   = RD_DATA;
            ptr_next     = ptr_reg + PTR_ONE;
            sda_oe_next  = ~RD_DATA[7];
         end
      end
   end

   always_ff @(posedge CLCK) begin
      if (RST) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         ptr_reg     <= '0;
         rw_reg      <= 1'b0;
         busy_reg    <= 1'b0;
         sda_oe_reg  <= 1'b0;
         wr_stb_reg  <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         ptr_reg     <= ptr_next;
         rw_reg      <= rw_next;
         busy_reg    <= busy_next;
         sda_oe_reg  <= sda_oe_next;
         wr_stb_reg  <= wr_stb_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
      end
   end

   assign SDA     = sda_oe_reg ? 1'b0 : 1'bz;
   assign RD_ADDR = ptr_reg;
   assign WR_STB  = wr_stb_reg;
   assign WR_ADDR = wr_addr_reg;
   assign WR_DATA = wr_data_reg;
   assign BUSY    = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged bus master, a fabric register array and
// a register-space model that predicts write strobes, read bytes and the pointer.
module tb_i2c_slave_regs;

   localparam int Q = 10;
   localparam int H = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_sda_oe = 1'b0;
   wire        sda_bus;
   logic [7:0] rd_data;
   logic [3:0] rd_addr;
   logic       wr_stb;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
   pullup (sda_bus);

   always #5 clk = ~clk;

   i2c_slave_regs #(.SLAVE_ADDR(7'h72), .ADDR_W(4), .FILT(3)) dut (
      .CLCK    (clk),
      .RST     (rst),
      .SCL     (scl),
      .SDA     (sda_bus),
      .RD_DATA (rd_data),
      .RD_ADDR (rd_addr),
      .WR_STB  (wr_stb),
      .WR_ADDR (wr_addr),
      .WR_DATA (wr_data),
      .BUSY    (busy)
   );

   // Fabric: register array loaded with identity on reset, plus activity counters.
   logic [7:0]  fab_mem [16];
   logic [11:0] wr_log [256];
   int          wr_cnt = 0;
   int          drive_cnt = 0;
   int          busy_cnt = 0;

   assign rd_data = fab_mem[rd_addr];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) fab_mem[i] <= 8'(i);
      end else if (wr_stb) begin
         fab_mem[wr_addr]    <= wr_data;
         wr_log[wr_cnt[7:0]] <= {wr_addr, wr_data};
         wr_cnt              <= wr_cnt + 1;
      end
      if (sda_bus === 1'b0 && !m_sda_oe) drive_cnt <= drive_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   int         checks = 0;
   int         failures = 0;
   logic [7:0] model_mem [16];
   int         model_ptr = 0;
   logic [7:0] wdat [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda_oe = 1'b0; wait_clk(Q);
      scl = 1'b1;      wait_clk(H);
      m_sda_oe = 1'b1; wait_clk(H);
      scl = 1'b0;      wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_sda_oe = 1'b1; wait_clk(Q);
      scl = 1'b1;      wait_clk(H);
      m_sda_oe = 1'b0; wait_clk(H);
   endtask

   // glitch: 1 = one-cycle SDA flip, 2 = one-cycle SCL drop, both while SCL is high
   task automatic put_bit(input logic b, input int glitch);
      m_sda_oe = ~b; wait_clk(Q);
      scl = 1'b1;    wait_clk(Q);
      if (glitch == 1) begin
         m_sda_oe = ~m_sda_oe; wait_clk(1);
         m_sda_oe = ~m_sda_oe; wait_clk(Q - 1);
      end else if (glitch == 2) begin
         scl = 1'b0; wait_clk(1);
         scl = 1'b1; wait_clk(Q - 1);
      end else begin
         wait_clk(Q);
      end
      scl = 1'b0; wait_clk(Q);
   endtask

   task automatic get_bit(output logic b);
      m_sda_oe = 1'b0; wait_clk(Q);
      scl = 1'b1;      wait_clk(Q);
      b = sda_bus;     wait_clk(Q);
      scl = 1'b0;      wait_clk(Q);
   endtask

   task automatic put_byte(input logic [7:0] d, input int g_sda, input int g_scl, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) put_bit(d[i], (i == g_sda) ? 1 : ((i == g_scl) ? 2 : 0));
      get_bit(b);
      ack = ~b;
   endtask

   task automatic get_byte(output logic [7:0] d, input logic master_ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(~master_ack, 0);
   endtask

   task automatic do_write(input logic [7:0] ptr_byte, input int n, input int g_sda,
                           input int g_scl, input string tag);
      logic a;
      int   base, p, ad;
      base = wr_cnt;
      p    = int'(ptr_byte) % 16;
      bus_start();
      put_byte(8'hE4, -1, -1, a);     chk({tag, "_addr_ack"}, 32'(a), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      put_byte(ptr_byte, -1, -1, a);  chk({tag, "_ptr_ack"}, 32'(a), 32'd1);
      for (int i = 0; i < n; i++) begin
         put_byte(wdat[i], (i == 0) ? g_sda : -1, (i == 0) ? g_scl : -1, a);
         chk({tag, "_data_ack"}, 32'(a), 32'd1);
      end
      bus_stop();
      chk({tag, "_wr_count"}, 32'(wr_cnt - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         ad = (p + i) % 16;
         chk({tag, "_wr_entry"}, {20'd0, wr_log[base + i]}, {20'd0, 4'(ad), wdat[i]});
         model_mem[ad] = wdat[i];
      end
      model_ptr = (p + n) % 16;
      chk({tag, "_ptr"}, 32'(rd_addr), 32'(model_ptr));
      chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic do_read(input logic [7:0] ptr_byte, input int n, input string tag);
      logic       a;
      logic [7:0] d;
      int         p;
      p = int'(ptr_byte) % 16;
      bus_start();
      put_byte(8'hE4, -1, -1, a);    chk({tag, "_waddr_ack"}, 32'(a), 32'd1);
      put_byte(ptr_byte, -1, -1, a); chk({tag, "_ptr_ack"}, 32'(a), 32'd1);
      bus_start();
      put_byte(8'hE5, -1, -1, a);    chk({tag, "_raddr_ack"}, 32'(a), 32'd1);
      for (int i = 0; i < n; i++) begin
         get_byte(d, i != n - 1);
         chk({tag, "_rd_byte"}, 32'(d), 32'(model_mem[(p + i) % 16]));
      end
      model_ptr = (p + n) % 16;
      chk({tag, "_busy_nack"}, 32'(busy), 32'd0);
      chk({tag, "_ptr"}, 32'(rd_addr), 32'(model_ptr));
      bus_stop();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish within time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a;
      logic [7:0] d;
      int         base, dbase, bbase, n;
      logic [7:0] pb;

      for (int i = 0; i < 16; i++) model_mem[i] = 8'(i);
      wait_clk(5);
      rst = 1'b0;
      wait_clk(5);

      chk("rst_sda", 32'(sda_bus), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_stb", 32'(wr_stb), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);

      wdat[0] = 8'hAA; wdat[1] = 8'h55;
      do_write(8'h05, 2, -1, -1, "t1");

      do_read(8'h02, 3, "t2");

      wdat[0] = 8'h11; wdat[1] = 8'h22;
      do_write(8'h0F, 2, -1, -1, "t3_wrap");

      // Foreign address: no acknowledge, no drive, no strobe, never busy
      base = wr_cnt; dbase = drive_cnt; bbase = busy_cnt;
      bus_start();
      put_byte(8'hA0, -1, -1, a); chk("t4_addr_ack", 32'(a), 32'd0);
      put_byte(8'h01, -1, -1, a); chk("t4_ptr_ack", 32'(a), 32'd0);
      put_byte(8'h33, -1, -1, a); chk("t4_data_ack", 32'(a), 32'd0);
      bus_stop();
      chk("t4_wr_count", 32'(wr_cnt - base), 32'd0);
      chk("t4_sda_driven", 32'(drive_cnt - dbase), 32'd0);
      chk("t4_busy_cycles", 32'(busy_cnt - bbase), 32'd0);
      chk("t4_ptr", 32'(rd_addr), 32'(model_ptr));

      wdat[0] = 8'h3C;
      do_write(8'h09, 1, 5, 2, "t5_glitch");

      for (int k = 0; k < 4; k++) begin
         pb = 8'($urandom);
         n  = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
         do_write(pb, n, -1, -1, "rnd_w");
         do_read(pb, n, "rnd_r");
      end

      // Reset during a driven read bit, then read from pointer 0
      wdat[0] = 8'h00;
      do_write(8'h07, 1, -1, -1, "t6_prep");
      bus_start();
      put_byte(8'hE4, -1, -1, a); chk("t6_waddr_ack", 32'(a), 32'd1);
      put_byte(8'h07, -1, -1, a); chk("t6_ptr_ack", 32'(a), 32'd1);
      bus_start();
      put_byte(8'hE5, -1, -1, a); chk("t6_raddr_ack", 32'(a), 32'd1);
      d = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         get_bit(a);
         d[7 - i] = a;
      end
      chk("t6_first_bits", 32'(d[7:5]), 32'd0);
      m_sda_oe = 1'b0; wait_clk(Q);
      scl = 1'b1;      wait_clk(Q);
      chk("t6_sda_before_rst", 32'(sda_bus), 32'd0);
      rst = 1'b1;      wait_clk(1);
      rst = 1'b0;
      chk("t6_sda_after_rst", 32'(sda_bus), 32'd1);
      wait_clk(Q - 1);
      scl = 1'b0;      wait_clk(Q);
      bus_stop();
      for (int i = 0; i < 16; i++) model_mem[i] = 8'(i);
      model_ptr = 0;
      chk("t6_rst_ptr", 32'(rd_addr), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      bus_start();
      put_byte(8'hE5, -1, -1, a); chk("t6_read_ack", 32'(a), 32'd1);
      get_byte(d, 1'b0);
      chk("t6_read_byte", 32'(d), 32'(model_mem[0]));
      chk("t6_read_ptr", 32'(rd_addr), 32'd1);
      bus_stop();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
